// File: rtl/dpll_ctrl_pkg.sv
// Shared constants for the CORDIC DPLL acquisition/lock controller.
// State encoding, default thresholds and the lgcoeff width.
package dpll_ctrl_pkg;

    localparam int LGC_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3
    } state_t;

    localparam logic [LGC_W-1:0] DEF_LGC_START = 5'd4;
    localparam logic [LGC_W-1:0] DEF_LGC_FINAL = 5'd8;

    localparam int DEF_LOCK_THRESH   = 512;
    localparam int DEF_UNLOCK_THRESH = 2048;
    localparam int DEF_LOCK_COUNT    = 4;
    localparam int DEF_LOSS_COUNT    = 2;
    localparam int DEF_TIMEOUT_WIN   = 256;

endpackage

// File: rtl/dpll_err_window.sv
// Windowed mean of |phase error|: saturating abs stage, then an
// accumulator that emits a one-cycle mean strobe every 2^LG_AVG samples.
module dpll_err_window #(
    parameter int OW     = 16,
    parameter int LG_AVG = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  logic          stb,
    input  logic [OW-1:0] err,
    output logic          mean_stb,
    output logic [OW-1:0] mean
);

    localparam int AW = OW + LG_AVG;
    localparam logic [OW-1:0] MOST_NEG = {1'b1, {(OW-1){1'b0}}};
    localparam logic [OW-1:0] MOST_POS = {1'b0, {(OW-1){1'b1}}};

    logic [OW-1:0]     abs_err;
    logic [OW-1:0]     mag;
    logic              mag_vld;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     sum;
    logic [LG_AVG-1:0] cnt;

    // The most negative code has no positive twin; clamp it.
    always_comb begin
        if (err == MOST_NEG)
            abs_err = MOST_POS;
        else if (err[OW-1])
            abs_err = -err;
        else
            abs_err = err;
    end

    assign sum = acc + AW'(mag);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            mag_vld  <= 1'b0;
            mag      <= '0;
            acc      <= '0;
            cnt      <= '0;
            mean_stb <= 1'b0;
            mean     <= '0;
        end else begin
            mag_vld  <= stb && en;
            mag      <= abs_err;
            mean_stb <= 1'b0;
            if (mag_vld) begin
                if (&cnt) begin
                    acc      <= '0;
                    cnt      <= '0;
                    mean_stb <= 1'b1;
                    mean     <= sum[AW-1:LG_AVG];
                end else begin
                    acc <= sum;
                    cnt <= cnt + LG_AVG'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dpll_lock_ctrl.sv
// Acquisition and lock controller for the CORDIC DPLL: loads the NCO
// step, gear-shifts lgcoeff from wide to narrow, and tracks lock.
module dpll_lock_ctrl
    import dpll_ctrl_pkg::*;
#(
    parameter int               OW            = 16,
    parameter int               PW            = 32,
    parameter int               LG_AVG        = 4,
    parameter logic [LGC_W-1:0] LGC_START     = DEF_LGC_START,
    parameter logic [LGC_W-1:0] LGC_FINAL     = DEF_LGC_FINAL,
    parameter int               LOCK_THRESH   = DEF_LOCK_THRESH,
    parameter int               UNLOCK_THRESH = DEF_UNLOCK_THRESH,
    parameter int               LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int               LOSS_COUNT    = DEF_LOSS_COUNT,
    parameter int               TIMEOUT_WIN   = DEF_TIMEOUT_WIN
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [PW-1:0]    i_step,
    input  logic             i_err_stb,
    input  logic [OW-1:0]    i_err,
    output logic             o_ld,
    output logic [PW-1:0]    o_step,
    output logic [LGC_W-1:0] o_lgcoeff,
    output logic             o_locked,
    output logic             o_fail,
    output logic [2:0]       o_state
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(LOSS_COUNT + 1);
    localparam int TW = $clog2(TIMEOUT_WIN + 1);

    state_t        state;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          active;
    logic          mean_stb;
    logic [OW-1:0] mean;
    logic          good_win;
    logic          bad_win;

    assign active   = (state == ST_ACQUIRE) || (state == ST_LOCKED);
    assign good_win = mean < OW'(LOCK_THRESH);
    assign bad_win  = mean >= OW'(UNLOCK_THRESH);
    assign o_state  = state;

    dpll_err_window #(
        .OW     (OW),
        .LG_AVG (LG_AVG)
    ) u_win (
        .clk      (i_clk),
        .reset    (i_reset),
        .clear    (i_start),
        .en       (active),
        .stb      (i_err_stb),
        .err      (i_err),
        .mean_stb (mean_stb),
        .mean     (mean)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            o_ld      <= 1'b0;
            o_step    <= '0;
            o_lgcoeff <= LGC_START;
            o_locked  <= 1'b0;
            o_fail    <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            tmo_cnt   <= '0;
        end else if (i_start) begin
            state     <= ST_LOAD;
            o_ld      <= 1'b1;
            o_step    <= i_step;
            o_lgcoeff <= LGC_START;
            o_locked  <= 1'b0;
            o_fail    <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            o_ld <= 1'b0;
            unique case (state)
                ST_IDLE: ;
                ST_LOAD: state <= ST_ACQUIRE;
                ST_ACQUIRE: if (mean_stb) begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    // Timeout wins over any gear or lock decision.
                    if (tmo_cnt == TW'(TIMEOUT_WIN - 1)) begin
                        o_fail <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (good_win) begin
                        if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                            good_cnt <= '0;
                            if (o_lgcoeff < LGC_FINAL) begin
                                o_lgcoeff <= o_lgcoeff + 5'd1;
                            end else begin
                                state    <= ST_LOCKED;
                                o_locked <= 1'b1;
                                bad_cnt  <= '0;
                            end
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end else begin
                        good_cnt <= '0;
                        if (bad_win)
                            o_lgcoeff <= LGC_START;
                    end
                end
                ST_LOCKED: if (mean_stb) begin
                    if (bad_win) begin
                        if (bad_cnt == BW'(LOSS_COUNT - 1)) begin
                            bad_cnt   <= '0;
                            o_locked  <= 1'b0;
                            o_lgcoeff <= LGC_START;
                            tmo_cnt   <= '0;
                            state     <= ST_ACQUIRE;
                        end else begin
                            bad_cnt <= bad_cnt + BW'(1);
                        end
                    end else begin
                        bad_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Bench for dpll_lock_ctrl: directed steps plus random windows,
// checked against a window-level behavioural model.
module tb_dpll_lock_ctrl;

    localparam int N_AVG   = 16;
    localparam int LGS     = 4;
    localparam int LGF     = 8;
    localparam int LOCK_T  = 512;
    localparam int UNLK_T  = 2048;
    localparam int LOCK_N  = 4;
    localparam int LOSS_N  = 2;
    localparam int TMO_N   = 256;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_step = '0;
    logic        i_err_stb = 1'b0;
    logic [15:0] i_err = '0;
    logic        o_ld;
    logic [31:0] o_step;
    logic [4:0]  o_lgcoeff;
    logic        o_locked;
    logic        o_fail;
    logic [2:0]  o_state;

    int n_vec = 0;
    int n_err = 0;

    // model state: 0 idle, 1 load, 2 acquire, 3 locked
    int          m_state, m_lg, m_good, m_bad, m_tmo;
    int          m_sum, m_n, m_pend, m_pmean;
    bit          m_ld, m_locked, m_fail;
    logic [31:0] m_step;

    dpll_lock_ctrl dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_step    (i_step),
        .i_err_stb (i_err_stb),
        .i_err     (i_err),
        .o_ld      (o_ld),
        .o_step    (o_step),
        .o_lgcoeff (o_lgcoeff),
        .o_locked  (o_locked),
        .o_fail    (o_fail),
        .o_state   (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mag_of(input logic [15:0] e);
        int v;
        v = int'($signed(e));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic logic [15:0] signed_err(input int m, input bit neg);
        int v;
        v = neg ? -m : m;
        return v[15:0];
    endfunction

    task automatic model_clear();
        m_lg = LGS; m_locked = 0; m_fail = 0;
        m_good = 0; m_bad = 0; m_tmo = 0;
        m_sum = 0; m_n = 0; m_pend = 0; m_pmean = 0;
    endtask

    task automatic decide(input int mean);
        if (m_state == 2) begin
            m_tmo++;
            if (m_tmo == TMO_N) begin
                m_fail = 1;
                m_state = 0;
            end else if (mean < LOCK_T) begin
                m_good++;
                if (m_good == LOCK_N) begin
                    m_good = 0;
                    if (m_lg < LGF) m_lg++;
                    else begin m_state = 3; m_locked = 1; m_bad = 0; end
                end
            end else begin
                m_good = 0;
                if (mean >= UNLK_T) m_lg = LGS;
            end
        end else if (m_state == 3) begin
            if (mean >= UNLK_T) begin
                m_bad++;
                if (m_bad == LOSS_N) begin
                    m_bad = 0; m_locked = 0; m_lg = LGS;
                    m_tmo = 0; m_state = 2;
                end
            end else begin
                m_bad = 0;
            end
        end
    endtask

    task automatic model_edge(input bit rst, input bit st,
                              input logic [31:0] stp, input bit stb,
                              input logic [15:0] e);
        bit acc;
        if (rst) begin
            model_clear();
            m_state = 0; m_step = '0;
        end else if (st) begin
            model_clear();
            m_state = 1; m_step = stp;
        end else begin
            acc = stb && (m_state == 2 || m_state == 3);
            if (m_state == 1) m_state = 2;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) decide(m_pmean);
            end
            if (acc) begin
                m_sum += mag_of(e);
                m_n++;
                if (m_n == N_AVG) begin
                    m_pmean = m_sum / N_AVG;
                    m_sum = 0; m_n = 0; m_pend = 2;
                end
            end
        end
        m_ld = (m_state == 1);
    endtask

    task automatic tick(input bit rst, input bit st, input logic [31:0] stp,
                        input bit stb, input logic [15:0] e);
        i_reset = rst; i_start = st; i_step = stp;
        i_err_stb = stb; i_err = e;
        @(posedge clk);
        model_edge(rst, st, stp, stb, e);
        #1;
        check("ld", o_ld, m_ld);
        check("step", o_step, m_step);
        check("lgcoeff", o_lgcoeff, m_lg);
        check("locked", o_locked, m_locked);
        check("fail", o_fail, m_fail);
        check("state", o_state, m_state);
    endtask

    task automatic feed(input int n, input logic [15:0] e);
        for (int k = 0; k < n; k++) tick(0, 0, 32'h0, 1, e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 32'h0, 0, 16'h0);
    endtask

    initial begin
        int cls;
        int wcnt;
        logic [15:0] e;
        m_state = 0; m_step = '0; m_ld = 0;
        model_clear();

        // reset values
        tick(1, 0, 32'h0, 0, 16'h0);
        tick(1, 0, 32'h0, 0, 16'h0);
        check("rst_lg", o_lgcoeff, 5'd4);
        check("rst_state", o_state, 3'd0);
        idle(2);

        // start, LOAD pulse, ACQUIRE
        tick(0, 1, 32'h0100_0000, 0, 16'h0);
        check("load_ld", o_ld, 1'b1);
        check("load_state", o_state, 3'd1);
        idle(1);
        check("acq_ld", o_ld, 1'b0);
        check("acq_step", o_step, 32'h0100_0000);
        check("acq_state", o_state, 3'd2);

        // gear shift to lock
        feed(64, 16'd100);
        idle(2);
        check("gear5", o_lgcoeff, 5'd5);
        feed(256, 16'd100);
        idle(1);
        check("prelock", o_locked, 1'b0);
        idle(1);
        check("lock", o_locked, 1'b1);
        check("lock_lg", o_lgcoeff, 5'd8);

        // loss of lock
        feed(32, signed_err(3000, 1));
        idle(2);
        check("unlock", o_locked, 1'b0);
        check("unlock_lg", o_lgcoeff, 5'd4);
        check("unlock_state", o_state, 3'd2);
        check("no_reload", o_step, 32'h0100_0000);

        // relock, single bad window keeps lock
        feed(320, 16'd100);
        idle(2);
        check("relock", o_locked, 1'b1);
        feed(16, signed_err(3000, 1));
        feed(16, 16'd100);
        idle(2);
        check("one_bad", o_locked, 1'b1);

        // most negative error saturates
        tick(0, 1, 32'h0200_0000, 0, 16'h0);
        idle(1);
        feed(64, 16'd100);
        idle(2);
        check("sat_pre_lg", o_lgcoeff, 5'd5);
        feed(16, 16'h8000);
        idle(1);
        check("sat_stb", dut.u_win.mean_stb, 1'b1);
        check("sat_mean", dut.u_win.mean, 16'd32767);
        idle(1);
        check("sat_lg", o_lgcoeff, 5'd4);

        // neutral errors until timeout
        tick(0, 1, 32'h0300_0000, 0, 16'h0);
        idle(1);
        feed(4096, 16'd1000);
        idle(2);
        check("tmo_fail", o_fail, 1'b1);
        check("tmo_state", o_state, 3'd0);
        check("tmo_lg", o_lgcoeff, 5'd4);
        tick(0, 1, 32'h0300_0000, 0, 16'h0);
        check("tmo_clear", o_fail, 1'b0);

        // start in LOCKED with a coincident strobe
        idle(1);
        feed(320, 16'd100);
        idle(2);
        check("lock2", o_locked, 1'b1);
        tick(0, 1, 32'h0400_0000, 1, 16'd100);
        check("start_unlock", o_locked, 1'b0);
        idle(1);
        feed(319, 16'd100);
        idle(2);
        check("relock_short", o_locked, 1'b0);
        feed(1, 16'd100);
        idle(2);
        check("relock_full", o_locked, 1'b1);

        // reset mid-window
        feed(8, signed_err(50, 1));
        tick(1, 0, 32'h0, 1, 16'd100);
        check("mrst_locked", o_locked, 1'b0);
        check("mrst_state", o_state, 3'd0);
        check("mrst_step", o_step, 32'h0);
        tick(0, 1, 32'h0500_0000, 0, 16'h0);
        idle(1);
        feed(320, 16'd100);
        idle(2);
        check("mrst_relock", o_locked, 1'b1);

        // random windows of mixed quality
        cls = 0;
        wcnt = 0;
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 2999) == 0) begin
                tick(1, 0, 32'h0, 0, 16'h0);
            end else if ($urandom_range(0, 799) == 0 || m_state == 0) begin
                tick(0, 1, $urandom, $urandom_range(0, 1), 16'd7);
            end else if ($urandom_range(0, 9) < 7) begin
                if (wcnt == 0) cls = $urandom_range(0, 9);
                wcnt = (wcnt + 1) % N_AVG;
                if (cls < 6)
                    e = signed_err($urandom_range(0, 500), $urandom_range(0, 1));
                else if (cls < 8)
                    e = signed_err($urandom_range(600, 1900), $urandom_range(0, 1));
                else if (cls < 9)
                    e = signed_err($urandom_range(2100, 32767), $urandom_range(0, 1));
                else
                    e = 16'h8000;
                tick(0, 0, 32'h0, 1, e);
            end else begin
                idle(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dpll_lock_ctrl.md
Name: dpll_lock_ctrl

Overview:
- Acquisition and lock controller for the CORDIC DPLL.
- Loads the NCO step, then "gear-shifts" the loop bandwidth: starts wide (small lgcoeff) and narrows by one step per stable interval until final lgcoeff.
- Declares lock from windowed mean |phase error|; reverts to wide bandwidth on loss of lock.
- Drives the DPLL's i_ld/i_step/i_lgcoeff inputs and consumes its o_err output, qualified by pd_done.

Parameters:
- OW, 16, phase-error width.
- PW, 32, phase/step width.
- LG_AVG, 4, log2 of error samples per window.
- LGC_START, 5'd4, acquisition lgcoeff.
- LGC_FINAL, 5'd8, tracking lgcoeff; must be >= LGC_START.
- LOCK_THRESH, 512, window mean below this is a "good" window.
- UNLOCK_THRESH, 2048, window mean at or above this is a "bad" window; must be > LOCK_THRESH.
- LOCK_COUNT, 4, consecutive good windows per gear step and to declare lock.
- LOSS_COUNT, 2, consecutive bad windows to drop lock.
- TIMEOUT_WIN, 256, maximum windows in ACQUIRE before failing.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset.
- i_start  in  1  one-cycle pulse: (re)start acquisition.
- i_step  in  PW  nominal NCO step, sampled with i_start.
- i_err_stb  in  1  error sample valid (DPLL pd_done).
- i_err  in  OW  signed phase error (DPLL o_err).
- o_ld  out  1  step-load pulse to DPLL.
- o_step  out  PW  step value to DPLL.
- o_lgcoeff  out  5  loop coefficient to DPLL.
- o_locked  out  1  lock indicator.
- o_fail  out  1  sticky acquisition-timeout flag.
- o_state  out  3  current state, for debug.

Behaviour:
- Interface: one clock, i_clk. Reset i_reset is synchronous and active-high.
- Reset values:
  - state IDLE.
  - o_ld=0, o_step=0, o_lgcoeff=LGC_START.
  - o_locked=0, o_fail=0.
  - All counters and the accumulator are 0.
- Reset asserted mid-operation restores all reset values at the next edge.
- States:
  - IDLE=0, LOAD=1, ACQUIRE=2, LOCKED=3.
- i_start, from any state:
  - Next state LOAD.
  - Latch o_step<=i_step.
  - o_lgcoeff<=LGC_START; o_locked<=0; o_fail<=0.
  - Clear the window accumulator, sample counter, good/bad/timeout counters.
  - i_start has priority over a same-cycle i_err_stb; that sample is dropped.
- LOAD: o_ld=1 for exactly this one cycle, then ACQUIRE. o_ld is registered and 0 in every other state.
- Error measurement is active in ACQUIRE and LOCKED only; strobes in IDLE and LOAD are ignored.
  - Stage 1: abs(i_err) registered. Saturating: -2^(OW-1) maps to 2^(OW-1)-1.
  - Stage 2: accumulate into an OW+LG_AVG-bit accumulator; no overflow is possible.
  - On the 2^LG_AVG-th sample: mean = sum>>LG_AVG. The accumulator restarts cleanly with the next sample.
  - Decision latency: the last strobe of a window is sampled at edge E; the resulting o_lgcoeff, o_locked and state changes are visible after edge E+2.
- ACQUIRE, per window:
  - Good window: good_cnt++.
  - On reaching LOCK_COUNT with o_lgcoeff<LGC_FINAL: o_lgcoeff++ and good_cnt<=0.
  - On reaching LOCK_COUNT with o_lgcoeff==LGC_FINAL: go to LOCKED, o_locked<=1.
  - Neutral window (between thresholds): good_cnt<=0.
  - Bad window: good_cnt<=0 and o_lgcoeff<=LGC_START.
  - Every window increments the timeout counter. At TIMEOUT_WIN: o_fail<=1, state IDLE, o_lgcoeff holds.
- LOCKED, per window:
  - Bad window: bad_cnt++.
  - On reaching LOSS_COUNT: o_locked<=0, o_lgcoeff<=LGC_START, state ACQUIRE, timeout counter cleared. The step is not reloaded.
  - Good or neutral window: bad_cnt<=0.
- Gear changes do not reset the window; windows stay contiguous.

Decomposition:
- Package dpll_ctrl_pkg holds:
  - state encoding constants.
  - default threshold/count constants.
  - 5-bit lgcoeff width constant.
- Sub-module dpll_err_window holds:
  - saturating abs.
  - accumulator.
  - sample counter.
  - outputs: one-cycle mean strobe plus OW-bit mean.
- The FSM stays in dpll_lock_ctrl.

Test Plan:
1. Reset, then i_start with i_step=32'h0100_0000 -> o_ld high exactly one cycle (LOAD), o_step=32'h0100_0000, o_lgcoeff=4, o_state=2.
2. Constant i_err=100 on every strobe -> o_lgcoeff steps 4->5->6->7->8 every 64 strobes; o_locked=1 two cycles after strobe 320.
3. LOCKED, then 32 strobes of i_err=-3000 -> o_locked=0 and o_lgcoeff=4 two cycles after strobe 32. A single bad window followed by good windows keeps o_locked=1.
4. i_err=16'h8000 for one window -> mean=32767, no wrap; in ACQUIRE o_lgcoeff returns to 4.
5. Constant i_err=1000 (neutral) -> o_lgcoeff stays 4; after 256 windows (4096 strobes) o_fail=1, o_state=0; a later i_start clears o_fail.
6. Assert i_start in LOCKED coincident with i_err_stb, and separately assert i_reset mid-window -> o_locked=0 next cycle, counters cleared, next lock requires a full 320 good strobes.
